even_operand_fetch: RTL and testbench

//  Register-fetch/forward (RF/FWD) stage feeding the even pipe: owns the 128x128 register array.

---
 rtl/even_operand_fetch_pkg.sv | 44 ++++
 rtl/even_operand_fetch_reg_array.sv | 38 +++
 rtl/even_operand_fetch.sv | 162 ++++++++++++++++
 tb/tb_even_operand_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/even_operand_fetch_pkg.sv
// Shared types and the operand forwarding priority resolver for the even-pipe fetch stage.
package even_operand_fetch_pkg;

   localparam int REG_W  = 128;
   localparam int ADDR_W = 7;
   localparam int NTAPS  = 6;
   localparam int NREGS  = 1 << ADDR_W;

   typedef enum logic [1:0] {
      UNIT_FP   = 2'd0,
      UNIT_FX2  = 2'd1,
      UNIT_BYTE = 2'd2,
      UNIT_FX1  = 2'd3
   } unit_t;

   typedef struct packed {
      logic [REG_W-1:0]  val;
      logic [ADDR_W-1:0] addr;
      logic              write;
   } fwd_tap_t;

   // Youngest producer wins: taps (lowest index first), then even WB, then odd WB, then array.
   function automatic logic [REG_W-1:0] fwd_select(
      input fwd_tap_t [NTAPS-1:0] taps,
      input logic                 ev_we,
      input logic [ADDR_W-1:0]    ev_addr,
      input logic [REG_W-1:0]     ev_val,
      input logic                 od_we,
      input logic [ADDR_W-1:0]    od_addr,
      input logic [REG_W-1:0]     od_val,
      input logic [REG_W-1:0]     arr_val,
      input logic [ADDR_W-1:0]    addr
   );
      logic [REG_W-1:0] v;
      v = arr_val;
      if (od_we && (od_addr == addr)) v = od_val;
      if (ev_we && (ev_addr == addr)) v = ev_val;
      for (int i = NTAPS - 1; i >= 0; i--) begin
         if (taps[i].write && (taps[i].addr == addr)) v = taps[i].val;
      end
      return v;
   endfunction

endpackage

// File: rtl/even_operand_fetch_reg_array.sv
// 128x128 register file: two write ports (even port wins on same address), three async reads.
// Synchronous reset clears every entry in one cycle.
module even_operand_fetch_reg_array
   import even_operand_fetch_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              ev_we_i,
   input  logic [ADDR_W-1:0] ev_addr_i,
   input  logic [REG_W-1:0]  ev_dat_i,
   input  logic              od_we_i,
   input  logic [ADDR_W-1:0] od_addr_i,
   input  logic [REG_W-1:0]  od_dat_i,
   input  logic [ADDR_W-1:0] ra_addr_i,
   input  logic [ADDR_W-1:0] rb_addr_i,
   input  logic [ADDR_W-1:0] rc_addr_i,
   output logic [REG_W-1:0]  ra_dat_o,
   output logic [REG_W-1:0]  rb_dat_o,
   output logic [REG_W-1:0]  rc_dat_o
);

   logic [REG_W-1:0] mem_q [NREGS];

   // Even write is issued last so it overrides the odd write to the same entry.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      end else begin
         if (od_we_i) mem_q[od_addr_i] <= od_dat_i;
         if (ev_we_i) mem_q[ev_addr_i] <= ev_dat_i;
      end
   end

   assign ra_dat_o = mem_q[ra_addr_i];
   assign rb_dat_o = mem_q[rb_addr_i];
   assign rc_dat_o = mem_q[rc_addr_i];

endmodule

// File: rtl/even_operand_fetch.sv
// Even-pipe register fetch/forward stage: resolves ra/rb/rc from taps, WB ports or array, 1-cycle latency.
// Stall holds the instruction but keeps reloading operands; flush turns the output into a nop.
module even_operand_fetch
   import even_operand_fetch_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [10:0]             in_op,
   input  logic [2:0]              in_format,
   input  logic [1:0]              in_unit,
   input  logic [ADDR_W-1:0]       in_rt_addr,
   input  logic [ADDR_W-1:0]       in_ra_addr,
   input  logic [ADDR_W-1:0]       in_rb_addr,
   input  logic [ADDR_W-1:0]       in_rc_addr,
   input  logic [17:0]             in_imm,
   input  logic                    in_reg_write,
   input  logic                    stall,
   input  logic                    flush,
   input  logic [NTAPS*REG_W-1:0]  tap_val,
   input  logic [NTAPS*ADDR_W-1:0] tap_addr,
   input  logic [NTAPS-1:0]        tap_write,
   input  logic [REG_W-1:0]        ev_wb_val,
   input  logic [ADDR_W-1:0]       ev_wb_addr,
   input  logic                    ev_wb_write,
   input  logic [REG_W-1:0]        od_wb_val,
   input  logic [ADDR_W-1:0]       od_wb_addr,
   input  logic                    od_wb_write,
   output logic [10:0]             op,
   output logic [2:0]              format,
   output logic [1:0]              unit,
   output logic [ADDR_W-1:0]       rt_addr,
   output logic [17:0]             imm,
   output logic [REG_W-1:0]        ra,
   output logic [REG_W-1:0]        rb,
   output logic [REG_W-1:0]        rc,
   output logic                    reg_write,
   output logic                    wb_conflict
);

   logic [10:0]       op_q, op_d;
   logic [2:0]        format_q, format_d;
   unit_t             unit_q, unit_d;
   logic [ADDR_W-1:0] rt_q, rt_d;
   logic [ADDR_W-1:0] ra_addr_q, ra_addr_d;
   logic [ADDR_W-1:0] rb_addr_q, rb_addr_d;
   logic [ADDR_W-1:0] rc_addr_q, rc_addr_d;
   logic [17:0]       imm_q, imm_d;
   logic              rw_q, rw_d;
   logic              conflict_q, conflict_d;
   logic [REG_W-1:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;

   fwd_tap_t [NTAPS-1:0] taps;
   logic [REG_W-1:0]     arr_ra, arr_rb, arr_rc;

   always_comb begin
      for (int i = 0; i < NTAPS; i++) begin
         taps[i].val   = tap_val[i*REG_W +: REG_W];
         taps[i].addr  = tap_addr[i*ADDR_W +: ADDR_W];
         taps[i].write = tap_write[i];
      end
   end

   // Held addresses double as the read addresses while stalled.
   always_comb begin
      op_d      = op_q;
      format_d  = format_q;
      unit_d    = unit_q;
      rt_d      = rt_q;
      ra_addr_d = ra_addr_q;
      rb_addr_d = rb_addr_q;
      rc_addr_d = rc_addr_q;
      imm_d     = imm_q;
      rw_d      = rw_q;
      if (!stall) begin
         op_d      = in_op;
         format_d  = in_format;
         unit_d    = unit_t'(in_unit);
         rt_d      = in_rt_addr;
         ra_addr_d = in_ra_addr;
         rb_addr_d = in_rb_addr;
         rc_addr_d = in_rc_addr;
         imm_d     = in_imm;
         rw_d      = in_valid & in_reg_write;
      end
      if (flush) begin
         op_d = '0;
         rw_d = 1'b0;
      end
      conflict_d = ev_wb_write & od_wb_write & (ev_wb_addr == od_wb_addr);
   end

   always_comb begin
      ra_d = fwd_select(taps, ev_wb_write, ev_wb_addr, ev_wb_val,
                        od_wb_write, od_wb_addr, od_wb_val, arr_ra, ra_addr_d);
      rb_d = fwd_select(taps, ev_wb_write, ev_wb_addr, ev_wb_val,
                        od_wb_write, od_wb_addr, od_wb_val, arr_rb, rb_addr_d);
      rc_d = fwd_select(taps, ev_wb_write, ev_wb_addr, ev_wb_val,
                        od_wb_write, od_wb_addr, od_wb_val, arr_rc, rc_addr_d);
   end

   even_operand_fetch_reg_array u_array (
      .clk_i     (clk),
      .reset_i   (reset),
      .ev_we_i   (ev_wb_write),
      .ev_addr_i (ev_wb_addr),
      .ev_dat_i  (ev_wb_val),
      .od_we_i   (od_wb_write),
      .od_addr_i (od_wb_addr),
      .od_dat_i  (od_wb_val),
      .ra_addr_i (ra_addr_d),
      .rb_addr_i (rb_addr_d),
      .rc_addr_i (rc_addr_d),
      .ra_dat_o  (arr_ra),
      .rb_dat_o  (arr_rb),
      .rc_dat_o  (arr_rc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q       <= '0;
         format_q   <= '0;
         unit_q     <= UNIT_FP;
         rt_q       <= '0;
         ra_addr_q  <= '0;
         rb_addr_q  <= '0;
         rc_addr_q  <= '0;
         imm_q      <= '0;
         rw_q       <= 1'b0;
         conflict_q <= 1'b0;
         ra_q       <= '0;
         rb_q       <= '0;
         rc_q       <= '0;
      end else begin
         op_q       <= op_d;
         format_q   <= format_d;
         unit_q     <= unit_d;
         rt_q       <= rt_d;
         ra_addr_q  <= ra_addr_d;
         rb_addr_q  <= rb_addr_d;
         rc_addr_q  <= rc_addr_d;
         imm_q      <= imm_d;
         rw_q       <= rw_d;
         conflict_q <= conflict_d;
         ra_q       <= ra_d;
         rb_q       <= rb_d;
         rc_q       <= rc_d;
      end
   end

   assign op          = op_q;
   assign format      = format_q;
   assign unit        = unit_q;
   assign rt_addr     = rt_q;
   assign imm         = imm_q;
   assign reg_write   = rw_q;
   assign wb_conflict = conflict_q;
   assign ra          = ra_q;
   assign rb          = rb_q;
   assign rc          = rc_q;

endmodule

// File: tb/tb_even_operand_fetch.sv
// Randomized and directed bench for even_operand_fetch against an array-based reference model.
module tb_even_operand_fetch;
   import even_operand_fetch_pkg::*;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    in_valid;
   logic [10:0]             in_op;
   logic [2:0]              in_format;
   logic [1:0]              in_unit;
   logic [ADDR_W-1:0]       in_rt_addr, in_ra_addr, in_rb_addr, in_rc_addr;
   logic [17:0]             in_imm;
   logic                    in_reg_write;
   logic                    stall, flush;
   logic [NTAPS*REG_W-1:0]  tap_val;
   logic [NTAPS*ADDR_W-1:0] tap_addr;
   logic [NTAPS-1:0]        tap_write;
   logic [REG_W-1:0]        ev_wb_val, od_wb_val;
   logic [ADDR_W-1:0]       ev_wb_addr, od_wb_addr;
   logic                    ev_wb_write, od_wb_write;
   logic [10:0]             op;
   logic [2:0]              format;
   logic [1:0]              unit;
   logic [ADDR_W-1:0]       rt_addr;
   logic [17:0]             imm;
   logic [REG_W-1:0]        ra, rb, rc;
   logic                    reg_write, wb_conflict;

   always #5 clk = ~clk;

   even_operand_fetch dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_format(in_format),
      .in_unit(in_unit), .in_rt_addr(in_rt_addr), .in_ra_addr(in_ra_addr),
      .in_rb_addr(in_rb_addr), .in_rc_addr(in_rc_addr), .in_imm(in_imm),
      .in_reg_write(in_reg_write), .stall(stall), .flush(flush), .tap_val(tap_val),
      .tap_addr(tap_addr), .tap_write(tap_write), .ev_wb_val(ev_wb_val),
      .ev_wb_addr(ev_wb_addr), .ev_wb_write(ev_wb_write), .od_wb_val(od_wb_val),
      .od_wb_addr(od_wb_addr), .od_wb_write(od_wb_write), .op(op), .format(format),
      .unit(unit), .rt_addr(rt_addr), .imm(imm), .ra(ra), .rb(rb), .rc(rc),
      .reg_write(reg_write), .wb_conflict(wb_conflict)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [REG_W-1:0] obs, input logic [REG_W-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference state: architectural registers plus the instruction currently on the outputs.
   logic [REG_W-1:0]  m_mem [NREGS];
   logic [10:0]       h_op;
   logic [2:0]        h_fmt;
   logic [1:0]        h_unit;
   logic [ADDR_W-1:0] h_rt, h_ra, h_rb, h_rc;
   logic [17:0]       h_imm;
   logic              h_rw, e_conf;
   logic [REG_W-1:0]  e_ra, e_rb, e_rc;

   function automatic logic [REG_W-1:0] m_resolve(input logic [ADDR_W-1:0] a);
      for (int i = 0; i < NTAPS; i++)
         if (tap_write[i] && tap_addr[i*ADDR_W +: ADDR_W] == a) return tap_val[i*REG_W +: REG_W];
      if (ev_wb_write && ev_wb_addr == a) return ev_wb_val;
      if (od_wb_write && od_wb_addr == a) return od_wb_val;
      return m_mem[a];
   endfunction

   task automatic idle();
      in_valid = 0; in_op = 0; in_format = 0; in_unit = 0; in_rt_addr = 0;
      in_ra_addr = 0; in_rb_addr = 0; in_rc_addr = 0; in_imm = 0; in_reg_write = 0;
      stall = 0; flush = 0; tap_val = '0; tap_addr = '0; tap_write = '0;
      ev_wb_val = '0; ev_wb_addr = 0; ev_wb_write = 0;
      od_wb_val = '0; od_wb_addr = 0; od_wb_write = 0;
   endtask

   task automatic set_tap(input int i, input logic [ADDR_W-1:0] a, input logic [REG_W-1:0] v);
      tap_write[i] = 1'b1;
      tap_addr[i*ADDR_W +: ADDR_W] = a;
      tap_val[i*REG_W +: REG_W] = v;
   endtask

   // Predict from current inputs, clock once, compare every output.
   task automatic step();
      logic [ADDR_W-1:0] a_ra, a_rb, a_rc;
      a_ra = stall ? h_ra : in_ra_addr;
      a_rb = stall ? h_rb : in_rb_addr;
      a_rc = stall ? h_rc : in_rc_addr;
      if (reset) begin
         for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
         h_op = 0; h_fmt = 0; h_unit = 0; h_rt = 0; h_ra = 0; h_rb = 0; h_rc = 0;
         h_imm = 0; h_rw = 0; e_conf = 0; e_ra = '0; e_rb = '0; e_rc = '0;
      end else begin
         e_ra = m_resolve(a_ra);
         e_rb = m_resolve(a_rb);
         e_rc = m_resolve(a_rc);
         e_conf = ev_wb_write && od_wb_write && (ev_wb_addr == od_wb_addr);
         if (!stall) begin
            h_op = in_op; h_fmt = in_format; h_unit = in_unit; h_rt = in_rt_addr;
            h_ra = in_ra_addr; h_rb = in_rb_addr; h_rc = in_rc_addr; h_imm = in_imm;
            h_rw = in_valid && in_reg_write;
         end
         if (flush) begin
            h_op = 0;
            h_rw = 0;
         end
         if (od_wb_write) m_mem[od_wb_addr] = od_wb_val;
         if (ev_wb_write) m_mem[ev_wb_addr] = ev_wb_val;
      end
      @(posedge clk);
      #1;
      check("op", REG_W'(op), REG_W'(h_op));
      check("format", REG_W'(format), REG_W'(h_fmt));
      check("unit", REG_W'(unit), REG_W'(h_unit));
      check("rt_addr", REG_W'(rt_addr), REG_W'(h_rt));
      check("imm", REG_W'(imm), REG_W'(h_imm));
      check("reg_write", REG_W'(reg_write), REG_W'(h_rw));
      check("wb_conflict", REG_W'(wb_conflict), REG_W'(e_conf));
      check("ra", ra, e_ra);
      check("rb", rb, e_rb);
      check("rc", rc, e_rc);
   endtask

   function automatic logic [REG_W-1:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      idle();
      reset = 1;
      step();
      step();
      reset = 0;

      // read r5 straight after reset
      in_ra_addr = 5;
      step();
      check("rst_r5_ra", ra, '0);
      check("rst_r5_rw", REG_W'(reg_write), '0);

      // array write then read
      idle(); ev_wb_write = 1; ev_wb_addr = 5; ev_wb_val = {16{8'hAA}};
      step();
      idle(); in_ra_addr = 5;
      step();
      check("r5_from_array", ra, {16{8'hAA}});

      // same-cycle writeback bypass
      idle(); ev_wb_write = 1; ev_wb_addr = 9; ev_wb_val = 128'd1; in_ra_addr = 9;
      step();
      check("r9_bypass", ra, 128'd1);

      // tap priority over higher taps and WB
      idle(); set_tap(0, 3, 128'd7); set_tap(4, 3, 128'd9);
      od_wb_write = 1; od_wb_addr = 3; od_wb_val = 128'd5; in_rb_addr = 3;
      step();
      check("rb_tap0", rb, 128'd7);

      // dual write to same address
      idle(); ev_wb_write = 1; ev_wb_addr = 10; ev_wb_val = 128'd1;
      od_wb_write = 1; od_wb_addr = 10; od_wb_val = 128'd2;
      step();
      check("conflict_set", REG_W'(wb_conflict), 128'd1);
      idle(); in_ra_addr = 10;
      step();
      check("r10_even_wins", ra, 128'd1);
      check("conflict_clear", REG_W'(wb_conflict), '0);

      // stall on rc=12, producer appears on tap2 mid-stall
      idle(); in_valid = 1; in_reg_write = 1; in_op = 11'h123; in_rc_addr = 12;
      step();
      in_op = 11'h7FF; in_rc_addr = 40; stall = 1;
      step();
      set_tap(2, 12, 128'h55);
      step();
      check("stall_rc_tap", rc, 128'h55);
      check("stall_op_hold", REG_W'(op), 128'h123);
      tap_write = '0;
      step();

      // flush beats stall
      flush = 1;
      step();
      check("flush_rw", REG_W'(reg_write), '0);
      check("flush_op", REG_W'(op), '0);

      // reset in the middle of a stall
      idle(); in_valid = 1; in_reg_write = 1; in_op = 11'h55; in_ra_addr = 10;
      step();
      stall = 1; set_tap(1, 10, rnd128()); reset = 1;
      step();
      check("rst_mid_ra", ra, '0);
      check("rst_mid_op", REG_W'(op), '0);
      reset = 0;

      // randomized traffic on a narrow address range to provoke hits
      for (int c = 0; c < 400; c++) begin
         idle();
         reset        = ($urandom_range(0, 99) < 2);
         in_valid     = $urandom_range(0, 1);
         in_reg_write = $urandom_range(0, 1);
         in_op        = 11'($urandom());
         in_format    = 3'($urandom());
         in_unit      = 2'($urandom());
         in_rt_addr   = 7'($urandom_range(0, 15));
         in_ra_addr   = 7'($urandom_range(0, 15));
         in_rb_addr   = 7'($urandom_range(0, 15));
         in_rc_addr   = 7'($urandom_range(0, 15));
         in_imm       = 18'($urandom());
         stall        = ($urandom_range(0, 99) < 25);
         flush        = ($urandom_range(0, 99) < 10);
         for (int t = 0; t < NTAPS; t++)
            if ($urandom_range(0, 2) == 0) set_tap(t, 7'($urandom_range(0, 15)), rnd128());
         ev_wb_write = $urandom_range(0, 1);
         ev_wb_addr  = 7'($urandom_range(0, 15));
         ev_wb_val   = rnd128();
         od_wb_write = $urandom_range(0, 1);
         od_wb_addr  = 7'($urandom_range(0, 15));
         od_wb_val   = rnd128();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
